seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CNT_MAX, default 49_999, meaning digit on-time minus one, in sys_clk cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 500, range >=1, meaning the inter-digit dead time in cycles (anti-ghosting).
REQ-003 SHALL have port sys_clk, input, 1 bit, meaning the single clock; all logic is in this domain.
REQ-004 SHALL have port sys_rst, input, 1 bit, meaning reset; it is asynchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit, meaning 1 = scan the display and 0 = blank it.
REQ-006 SHALL have port upd_valid, input, 1 bit, meaning a new display value is offered.
REQ-007 SHALL have port upd_ready, output, 1 bit, meaning the block can accept a value.
REQ-008 SHALL have port upd_bcd, input, 24 bits, meaning six nibbles where nibble 0 (bits 3:0) is the rightmost digit.
REQ-009 SHALL have port upd_dp, input, 6 bits, meaning a decimal-point enable per digit.
REQ-010 SHALL have port seg, output, 8 bits, meaning segment drive to hc595_ctrl; active-low, bit 7 = dp, bits 6:0 = g..a.
REQ-011 SHALL have port sel, output, 6 bits, meaning digit select to hc595_ctrl; one-hot, active-high.
REQ-012 SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse at the end of each frame.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, ON, BLANK.
  - IDLE: sel=0, seg=8'hFF.
  - ON: sel=1<<digit, seg=glyph(digit).
  - BLANK: sel=0, seg=8'hFF.
REQ-014 SHALL make the following transitions:
  - IDLE->ON(digit 0) on the cycle after en=1 is sampled.
  - ON->BLANK after CNT_MAX+1 cycles.
  - BLANK->ON(digit+1) after BLANK_CYC cycles; digit 5 wraps to digit 0.
REQ-015 SHALL give a frame length of 6*(CNT_MAX+1+BLANK_CYC) cycles.
REQ-016 SHALL pulse frame_done for one cycle on the last BLANK cycle of digit 5.
REQ-017 SHALL, when en=0 is sampled in any state, enter IDLE next cycle and clear the digit and cycle counters; re-enable restarts at digit 0 with a full ON period.
REQ-018 SHALL decode glyphs as follows:
  - Nibble 0-9: standard common-anode pattern (0 -> 8'hC0, 8 -> 8'h80).
  - Nibble 10-15: "-" (8'hBF).
  - dp: clears bit 7 of the glyph.
REQ-019 SHALL suppress leading zeros: a digit above the most significant nonzero nibble shows 8'hFF unless its dp bit is set; digit 0 is never suppressed.
REQ-020 SHALL hold one pending register and one display register; upd_ready = NOT pending_full.
REQ-021 SHALL, on upd_valid&&upd_ready, capture upd_bcd/upd_dp into pending and set pending_full on the next edge.
REQ-022 SHALL transfer pending to display (and clear pending_full) only on the frame_done cycle or on any IDLE cycle, so a frame never mixes two values.
REQ-023 SHALL never let accept and transfer coincide (ready=0 whenever pending_full=1); upd_valid held while ready=0 SHALL stall without loss.
REQ-024 SHALL make seg and sel registered outputs, with a one-cycle lag from the state/digit register.

Reset
REQ-025 SHALL, on sys_rst=1 (asynchronous), set: state=IDLE, digit=0, counters=0, seg=8'hFF, sel=6'b0, frame_done=0, pending_full=0 (upd_ready=1), display=0, dp=0.
REQ-026 SHALL discard any pending update when sys_rst asserts mid-frame; after release, the display shows "0" on digit 0 once en=1.

Structure
REQ-027 SHALL place in a shared package seg_pkg: NUM_DIG=6, the glyph constants (0-9, dash, blank), and the state enum.
REQ-028 SHALL implement the nibble-to-glyph decode as a combinational sub-module, seg_glyph_dec, reusable by other display blocks.
REQ-029 SHALL keep the implementation to one sequential FSM/counter process plus the handshake registers, within 120-400 lines of RTL.

Verification (CNT_MAX=3, BLANK_CYC=2)
REQ-030 Reset then en=1: sel sequence 000001 x4 cycles, 000000 x2, 000010 x4 …; frame_done every 36 cycles; seg=8'hC0 only while sel=000001.
REQ-031 Update bcd=24'h001234, dp=6'b000100 mid-frame: the current frame is unchanged; the next frame shows 4,3,2(dp, 8'h24),1 with digits 4-5 = 8'hFF.
REQ-032 Two back-to-back updates: the second sees upd_ready=0 until the frame_done cycle, then is accepted; no value is lost or torn.
REQ-033 en=0 during digit 3 ON: next cycle sel=0, seg=8'hFF; a pending update is applied in IDLE; en=1 restarts at digit 0 with the new value.
REQ-034 Nibble 4'hB on digit 2, with all higher digits zero and no dp: digit 2 shows 8'hBF and digits 3-5 are blank.
REQ-035 sys_rst pulse mid-frame with pending_full=1: outputs blank immediately (asynchronously), upd_ready=1 after release, and pending is not displayed.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: digit count, glyph codes, scan states.
// Latency: n/a (constants, types and a pure combinational helper).
// Backpressure: n/a.
package seg_pkg;

    localparam int NUM_DIG = 6;

    // Common-anode, active-low glyphs: bit 7 = dp, bits 6:0 = g..a
    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        BLANK = 2'd2
    } state_t;

    // True when nibble idx and every nibble above it are zero (leading-zero region)
    function automatic logic upper_zero(input logic [NUM_DIG*4-1:0] bcd, input logic [2:0] idx);
        logic z;
        z = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (i >= int'(idx) && bcd[4*i +: 4] != 4'd0) z = 1'b0;
        end
        return z;
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Nibble to active-low 7-segment glyph decoder with decimal point and blanking.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] glyph
);

    logic [7:0] pat;

    // Map the nibble to its pattern, then apply blanking or the decimal point
    always_comb begin
        case (nib)
            4'd0:    pat = GLYPH_0;
            4'd1:    pat = GLYPH_1;
            4'd2:    pat = GLYPH_2;
            4'd3:    pat = GLYPH_3;
            4'd4:    pat = GLYPH_4;
            4'd5:    pat = GLYPH_5;
            4'd6:    pat = GLYPH_6;
            4'd7:    pat = GLYPH_7;
            4'd8:    pat = GLYPH_8;
            4'd9:    pat = GLYPH_9;
            default: pat = GLYPH_DASH;
        endcase
        if (blank) glyph = GLYPH_BLANK;
        else       glyph = pat & {~dp, 7'h7F};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed 7-segment scanner with anti-ghost blanking and frame-atomic value updates.
// Latency: seg/sel lag the state/digit register by one cycle; a value accepted mid-frame shows from the next frame.
// Backpressure: upd_ready drops while a value is pending; it reopens on the frame_done cycle or in IDLE.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CNT_MAX   = 49_999,
    parameter int BLANK_CYC = 500
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [23:0] upd_bcd,
    input  logic [5:0]  upd_dp,
    output logic [7:0]  seg,
    output logic [5:0]  sel,
    output logic        frame_done
);

    localparam int CMAX = (CNT_MAX > BLANK_CYC) ? CNT_MAX : BLANK_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(CNT_MAX);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [2:0]    LAST_DIG   = 3'(NUM_DIG - 1);

    state_t        state;
    logic [2:0]    digit;
    logic [CW-1:0] cnt;

    logic [23:0]   pend_bcd;
    logic [5:0]    pend_dp;
    logic          pend_full;
    logic [23:0]   disp_bcd;
    logic [5:0]    disp_dp;

    logic [3:0]    nib;
    logic          dpb;
    logic          lz_blank;
    logic [7:0]    glyph;
    logic          frame_end;
    logic          accept;
    logic          xfer;

    assign upd_ready = ~pend_full;
    assign accept    = upd_valid & ~pend_full;
    assign frame_end = (state == BLANK) && (cnt == BLANK_LAST) && (digit == LAST_DIG);
    // Swap only at a frame boundary or while idle, so a frame never mixes two values
    assign xfer      = pend_full & ((frame_end & en) | (state == IDLE));

    // Select the current digit's nibble/dp and decide leading-zero suppression
    always_comb begin
        nib = disp_bcd[3:0];
        dpb = disp_dp[0];
        for (int i = 0; i < NUM_DIG; i++) begin
            if (digit == 3'(i)) begin
                nib = disp_bcd[4*i +: 4];
                dpb = disp_dp[i];
            end
        end
        lz_blank = (digit != 3'd0) && !dpb && upper_zero(disp_bcd, digit);
    end

    seg_glyph_dec u_dec (
        .nib   (nib),
        .dp    (dpb),
        .blank (lz_blank),
        .glyph (glyph)
    );

    // Scan FSM: ON/BLANK timing, digit rotation and registered display outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            digit      <= 3'd0;
            cnt        <= '0;
            seg        <= GLYPH_BLANK;
            sel        <= 6'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            seg        <= GLYPH_BLANK;
            sel        <= 6'd0;
            if (!en) begin
                // Outputs blank on the same edge that drops to IDLE
                state <= IDLE;
                digit <= 3'd0;
                cnt   <= '0;
            end else begin
                if (state == ON) begin
                    seg <= glyph;
                    sel <= 6'd1 << digit;
                end
                case (state)
                    IDLE: begin
                        state <= ON;
                        digit <= 3'd0;
                        cnt   <= '0;
                    end
                    ON: begin
                        if (cnt == ON_LAST) begin
                            state <= BLANK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state      <= ON;
                            cnt        <= '0;
                            digit      <= (digit == LAST_DIG) ? 3'd0 : digit + 3'd1;
                            frame_done <= (digit == LAST_DIG);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        digit <= 3'd0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Update handshake: one pending slot feeding the display register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pend_full <= 1'b0;
            pend_bcd  <= 24'd0;
            pend_dp   <= 6'd0;
            disp_bcd  <= 24'd0;
            disp_dp   <= 6'd0;
        end else if (accept) begin
            pend_bcd  <= upd_bcd;
            pend_dp   <= upd_dp;
            pend_full <= 1'b1;
        end else if (xfer) begin
            disp_bcd  <= pend_bcd;
            disp_dp   <= pend_dp;
            pend_full <= 1'b0;
        end
    end

endmodule
